// File: rtl/sw_debounce4_pkg.sv
// Shared board constants, debounce FSM state encoding and parameter helpers
// for the four-channel switch debouncer.
package sw_debounce4_pkg;

  localparam int CLK_HZ      = 100_000_000;
  localparam int DEBOUNCE_MS = 10;

  // Cycles a new level must hold before it is committed (10 ms at 100 MHz)
  localparam int DEFAULT_STABLE_CNT = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int DEFAULT_CNT_W      = 20;

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    S_WAIT_HI = 2'd1,
    S_HIGH    = 2'd2,
    S_WAIT_LO = 2'd3
  } db_state_e;

  // True when a CNT_W-bit counter can hold every value up to stable_cnt
  function automatic bit cnt_fits(input int stable_cnt, input int cnt_w);
    longint unsigned span;
    span = 64'd1 << cnt_w;
    return (span > longint'(stable_cnt));
  endfunction

endpackage

// File: rtl/sw_debounce4_chan.sv
// One debounce channel: two-flop synchroniser, stability counter, four-state
// commit FSM and registered level/rise/fall outputs.
module debounce_chan
  import sw_debounce4_pkg::*;
#(
  parameter int STABLE_CNT = DEFAULT_STABLE_CNT,
  parameter int CNT_W      = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic sw_db,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] LP_LAST     = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] LP_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_ZERO     = CNT_W'(0);
  localparam logic             LP_ONE_SHOT = (STABLE_CNT == 1) ? 1'b1 : 1'b0;

  if (STABLE_CNT < 1) begin : g_bad_stable
    $error("debounce_chan: STABLE_CNT must be >= 1");
  end
  if (!cnt_fits(STABLE_CNT, CNT_W)) begin : g_bad_cnt_w
    $error("debounce_chan: 2**CNT_W must exceed STABLE_CNT");
  end

  logic             r_s1;
  logic             r_s2;
  db_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_db;
  logic             r_rise;
  logic             r_fall;

  db_state_e        w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_db_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;

  // Synchroniser: only r_s2 is ever looked at by the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= sw_raw;
      r_s2 <= r_s1;
    end
  end

  // FSM, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LOW;
      r_cnt   <= LP_ZERO;
      r_db    <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_db    <= w_db_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // Next-state: any reversal of r_s2 before commit drops back and clears the count
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_db_nxt    = r_db;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      S_LOW: begin
        if (r_s2 && LP_ONE_SHOT) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = LP_ZERO;
          w_db_nxt    = 1'b1;
          w_rise_nxt  = 1'b1;
        end else if (r_s2) begin
          w_state_nxt = S_WAIT_HI;
          w_cnt_nxt   = LP_ONE;
        end else begin
          w_cnt_nxt   = LP_ZERO;
        end
      end
      S_WAIT_HI: begin
        if (!r_s2) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = LP_ZERO;
        end else if (r_cnt == LP_LAST) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = LP_ZERO;
          w_db_nxt    = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + LP_ONE;
        end
      end
      S_HIGH: begin
        if (!r_s2 && LP_ONE_SHOT) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = LP_ZERO;
          w_db_nxt    = 1'b0;
          w_fall_nxt  = 1'b1;
        end else if (!r_s2) begin
          w_state_nxt = S_WAIT_LO;
          w_cnt_nxt   = LP_ONE;
        end else begin
          w_cnt_nxt   = LP_ZERO;
        end
      end
      S_WAIT_LO: begin
        if (r_s2) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = LP_ZERO;
        end else if (r_cnt == LP_LAST) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = LP_ZERO;
          w_db_nxt    = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + LP_ONE;
        end
      end
      default: begin
        w_state_nxt = S_LOW;
        w_cnt_nxt   = LP_ZERO;
        w_db_nxt    = 1'b0;
      end
    endcase
  end

  assign sw_db = r_db;
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule

// File: rtl/sw_debounce4.sv
// Four independent switch debouncers feeding the a/b/c/d inputs of the AOI stage,
// plus a registered "any channel changed" flag one cycle behind the pulses.
module sw_debounce4
  import sw_debounce4_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int STABLE_CNT = DEFAULT_STABLE_CNT,
  parameter int CNT_W      = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  logic [WIDTH-1:0] w_db;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic             r_changed;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    debounce_chan #(
      .STABLE_CNT (STABLE_CNT),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .sw_raw (sw_raw[gi]),
      .sw_db  (w_db[gi]),
      .rise   (w_rise[gi]),
      .fall   (w_fall[gi])
    );
  end

  // Aggregate event flag, deliberately one cycle behind rise/fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= |(w_rise | w_fall);
    end
  end

  assign sw_db   = w_db;
  assign rise    = w_rise;
  assign fall    = w_fall;
  assign changed = r_changed;

endmodule
